// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit.
//   op_e    : operation encodings carried on the 2-bit op bus
//   state_e : control FSM states (IDLE -> RUN -> FIX -> IDLE)
// -----------------------------------------------------------------------------
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_unit_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One iteration of unsigned restoring division (purely combinational).
//   rem      : partial remainder, always < divisor between iterations
//   quo      : dividend bits still to be consumed in the upper end, quotient
//              bits accumulating in the lower end
//   divisor  : unsigned divisor
//   next_rem : partial remainder after this iteration
//   next_quo : quo shifted left with the new quotient bit inserted at bit 0
// With divisor = 0 the trial subtraction never borrows, so after WIDTH
// iterations the quotient is all ones and the remainder equals the dividend.
// -----------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic [WIDTH-1:0] next_quo
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           borrow;

  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    borrow  = diff[WIDTH];
    // Restore (keep the shifted value) when the trial subtraction borrows.
    next_rem = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    next_quo = {quo[WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative multiply/divide unit with architectural HI/LO registers.
// One bit per cycle: WIDTH iterations in RUN, sign correction and HI/LO write
// in FIX. MFHI/MFLO read hi/lo directly.
//   clk, rst      : clock, asynchronous active-high reset
//   start, op     : launch MULT/MULTU/DIV/DIVU (only sampled in IDLE)
//   a, b          : rs / rt operands
//   flush         : abort the in-flight operation, HI/LO untouched
//   we_hi, we_lo  : MTHI / MTLO write enables (IDLE only), data on wdata
//   busy          : operation in flight
//   stall         : freeze request for the hazard unit
//   done          : one-cycle pulse once hi/lo hold the new result
//   hi, lo        : HI / LO registers
// -----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_e state, state_next;

  // acc holds the running product for multiplies ({upper, shifting multiplier})
  // and {remainder, quotient/dividend} for divides, so both share one register.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;     // multiplicand or divisor magnitude
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               neg_res;  // negate product / quotient in FIX
  logic               neg_rem;  // negate remainder in FIX

  logic load, step, commit;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every clocked process uses non-blocking assignments so all
    // registers update from the same pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: defaults first, so no path through this block leaves a signal
    // unassigned and infers a latch.
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    commit     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !flush) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          state_next = IDLE;
        end else begin
          step = 1'b1;
          if (cnt == LAST_ITER) state_next = FIX;
        end
      end
      FIX: begin
        state_next = IDLE;
        commit     = !flush;
      end
      default: state_next = IDLE;
    endcase
  end

  // The cycle right after launch (RUN, nothing iterated yet) is not counted as
  // busy; busy covers the WIDTH-1 remaining RUN cycles plus FIX.
  assign busy  = (state == FIX) || ((state == RUN) && (cnt != '0));
  assign stall = ((state == IDLE) && start && !flush) || busy;

  // ---------------------------------------------------------------------------
  // Operand conditioning at launch
  // ---------------------------------------------------------------------------
  logic             op_signed, op_div, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    op_div    = (op == OP_DIV) || (op == OP_DIVU);
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = op_signed && a[WIDTH-1];
    b_neg     = op_signed && b[WIDTH-1];
    // -MIN wraps to MIN, which is exactly the unsigned magnitude 2^(WIDTH-1).
    mag_a     = a_neg ? -a : a;
    mag_b     = b_neg ? -b : b;
  end

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH-1:0]   div_rem, div_quo;

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
             + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (acc[2*WIDTH-1:WIDTH]),
    .quo      (acc[WIDTH-1:0]),
    .divisor  (opnd),
    .next_rem (div_rem),
    .next_quo (div_quo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      opnd    <= '0;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
    end else if (load) begin
      acc     <= op_div ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
      opnd    <= op_div ? mag_b : mag_a;
      cnt     <= '0;
      is_div  <= op_div;
      neg_res <= a_neg ^ b_neg;
      neg_rem <= op_div && a_neg;
    end else if (step) begin
      acc <= is_div ? {div_rem, div_quo} : mul_next;
      cnt <= cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Sign correction and HI/LO
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, res_hi, res_lo;

  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    res_hi   = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = is_div ? quo_fix : prod_fix[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= commit;
      if (commit) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (state == IDLE) begin
        // MTHI/MTLO in the launch cycle land now; the result overwrites later.
        if (we_hi) hi <= wdata;
        if (we_lo) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed bench for muldiv_unit (WIDTH=32): a table of operations with
// hand-computed HI/LO values plus sequences for flush, asynchronous reset in
// mid-operation, and start / MTLO attempts while busy.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         flush = 1'b0;
  logic         we_hi = 1'b0;
  logic         we_lo = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         busy, stall, done;
  logic [W-1:0] hi, lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .we_hi (we_hi),
    .we_lo (we_lo),
    .wdata (wdata),
    .busy  (busy),
    .stall (stall),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  localparam int NV = 10;
  vec_t vec [NV];

  // Launches one operation and watches 45 cycles after the launch edge.
  // k counts the cycle following edge k. When k == inject, a start (DIVU 1/1)
  // and an MTLO write are attempted for one cycle.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input int inject, output int busy_cnt, output int stall_cnt,
                       output int done_cnt, output int lat, output logic stall_pre);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    #1 stall_pre = stall;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0; stall_cnt = 0; done_cnt = 0; lat = -1;
    for (int k = 0; k < 45; k++) begin
      if (k == inject) begin
        start = 1'b1; op = OP_DIVU; a = 32'd1; b = 32'd1;
        we_lo = 1'b1; wdata = 32'h0000DEAD;
      end else if (k == inject + 1) begin
        start = 1'b0; we_lo = 1'b0;
      end
      #1;
      if (busy)  busy_cnt++;
      if (stall) stall_cnt++;
      if (done) begin
        done_cnt++;
        if (lat < 0) lat = k;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_timing(input string tag, input int busy_cnt, input int stall_cnt,
                              input int done_cnt, input int lat, input logic stall_pre);
    check({tag, "_busy_cycles"},  W'(busy_cnt),  32'd32);
    check({tag, "_stall_cycles"}, W'(stall_cnt), 32'd32);
    check({tag, "_done_pulses"},  W'(done_cnt),  32'd1);
    check({tag, "_done_cycle"},   W'(lat),       32'd33);
    check({tag, "_stall_launch"}, W'(stall_pre), 32'd1);
  endtask

  int   bc, sc, dc, lt;
  logic sp;
  int   flush_done;

  initial begin
    vec[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vec[1] = '{OP_MULT,  32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFD6};
    vec[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vec[3] = '{OP_DIVU,  32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF};
    vec[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vec[5] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'h00000001};
    vec[6] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vec[7] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vec[8] = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vec[9] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", W'(busy), 32'd0);
    check("rst_done", W'(done), 32'd0);
    check("rst_stall", W'(stall), 32'd0);
    rst = 1'b0;

    // Table of operations
    for (int i = 0; i < NV; i++) begin
      do_op(vec[i].op, vec[i].a, vec[i].b, -1, bc, sc, dc, lt, sp);
      check($sformatf("v%0d_hi", i), hi, vec[i].hi);
      check($sformatf("v%0d_lo", i), lo, vec[i].lo);
      check_timing($sformatf("v%0d", i), bc, sc, dc, lt, sp);
    end

    // MTHI, then flush a DIVU in mid-run
    @(negedge clk);
    we_hi = 1'b1; wdata = 32'h11;
    @(negedge clk);
    we_hi = 1'b0;
    check("mthi_hi", hi, 32'h11);
    op = OP_DIVU; a = 32'd50; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1 check("flush_busy", W'(busy), 32'd0);
    flush_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) flush_done++;
    end
    check("flush_done_pulses", W'(flush_done), 32'd0);
    check("flush_hi", hi, 32'h11);
    check("flush_lo", lo, vec[NV-1].lo);
    do_op(OP_DIVU, 32'd50, 32'd7, -1, bc, sc, dc, lt, sp);
    check("after_flush_hi", hi, 32'd1);
    check("after_flush_lo", lo, 32'd7);
    check_timing("after_flush", bc, sc, dc, lt, sp);

    // Asynchronous reset between edges 4 and 5 of a MULTU
    @(negedge clk);
    op = OP_MULTU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", W'(busy), 32'd0);
    check("arst_done", W'(done), 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("arst_idle_busy", W'(busy), 32'd0);

    // Start and MTLO attempted while busy are both ignored
    do_op(OP_MULT, 32'hFFFFFFF9, 32'd6, 5, bc, sc, dc, lt, sp);
    check("busy_ign_hi", hi, 32'hFFFFFFFF);
    check("busy_ign_lo", lo, 32'hFFFFFFD6);
    check_timing("busy_ign", bc, sc, dc, lt, sp);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers, beside the ALU in the execute stage of the pipelined MIPS core.
- Handles MULT, MULTU, DIV, DIVU, MTHI and MTLO; MFHI/MFLO read hi/lo combinationally.
- Parametrised in operand width. Uses a start/busy/done handshake and drives a stall that the hazard unit ORs into stallF/stallD.
- Supports abort on pipeline flush.

Parameters:
- WIDTH, 32, operand width; hi/lo are WIDTH bits each, product is 2*WIDTH.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  launch operation; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  rs operand (multiplicand / dividend).
- b  in  WIDTH  rt operand (multiplier / divisor).
- flush  in  1  abort in-flight operation (from flushE).
- we_hi  in  1  MTHI write.
- we_lo  in  1  MTLO write.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in flight.
- stall  out  1  start & IDLE, or busy; hazard unit freezes F/D/E.
- done  out  1  one-cycle pulse; hi/lo hold the new result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, any state) forces:
  - state IDLE;
  - hi=0, lo=0;
  - busy=0, done=0;
  - counter=0;
  - an in-flight operation is discarded.
- States: IDLE, RUN, FIX.
- IDLE, start=1 and flush=0:
  - latch |a|, |b| for signed ops, else a and b raw;
  - latch result-sign flags;
  - counter=0; go to RUN.
- RUN: one iteration per cycle.
  - MUL: shift-add into a 2*WIDTH accumulator.
  - DIV: restoring subtract-shift into remainder/quotient.
  - After WIDTH iterations, go to FIX.
- FIX:
  - apply sign correction (negate product, quotient or remainder as required);
  - write hi/lo; done=1 for that cycle; return to IDLE.
- Latency:
  - start sampled at edge 0; results visible in hi/lo after edge WIDTH+1;
  - busy=1 from edge 1 through edge WIDTH+1 (exclusive);
  - done asserted in the cycle after edge WIDTH+1.
- stall is combinational: (state==IDLE & start & ~flush) | busy.
- MUL results: hi = product[2W-1:W], lo = product[W-1:0].
- DIV results: lo = quotient, hi = remainder.
  - Quotient is negative iff operand signs differ (signed only).
  - Remainder takes the sign of the dividend.
- Divide by zero, no trap:
  - DIVU: lo = all ones, hi = a.
  - DIV: lo = (a<0 ? 1 : all ones), hi = a. This is the result of the restoring algorithm plus sign fix, and is specified here as required.
- Signed overflow, DIV of MIN by -1: lo=MIN, hi=0.
- flush while in RUN or FIX: next state IDLE, hi/lo unchanged, done stays 0.
- flush together with start in IDLE: start ignored.
- start while busy: ignored; no queueing.
- we_hi/we_lo:
  - honoured only when state==IDLE; ignored while busy, since the pipeline is stalled and cannot issue them.
  - In the same cycle as start, the write takes effect and the later result overwrites it.
- No combinational path from a/b to hi/lo.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - state enum IDLE/RUN/FIX.
- Sub-module div_step (combinational, WIDTH-parametrised): one restoring-division iteration, taking remainder/quotient and divisor and returning the next remainder/quotient.
- Multiply step is inline.

Test Plan (WIDTH=32):
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 33 edges hi=0xFFFFFFFE, lo=0x00000001; done pulses exactly once; busy high 32 cycles.
- MULT a=-7 (0xFFFFFFF9), b=6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6; DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Set hi=0x11 via MTHI; start DIVU 50/7; assert flush at cycle 10 -> busy=0 next cycle, done never asserts, hi=0x11 retained; a new start then completes normally (lo=7, hi=1).
- Assert rst mid-RUN (cycle 5), asynchronously between edges -> busy/done/hi/lo drop to 0 immediately. Start during busy and we_lo during busy -> both ignored, result unchanged.
